// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of a PWM input and flags a stuck line
module pwm_capture #(
  parameter int R  = 8,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          pwm_in,
  output logic [R-1:0]  duty_out,
  output logic [PW-1:0] high_count,
  output logic [PW-1:0] period_count,
  output logic          period_match,
  output logic          valid,
  output logic          stuck,
  output logic          stuck_level
);
  typedef enum logic [1:0] {IDLE, MEAS, STUCK} state_t;
  localparam logic [PW-1:0] CMAX = '1;
  localparam logic [PW-1:0] NOM  = PW'(1) << R;
  localparam logic [R-1:0]  DSAT = '1;
  state_t state, state_nx;
  logic s1, s2, s3, rise, publish, timeout;
  logic [PW-1:0] cnt, hcnt;
  assign rise    = s2 & ~s3;
  assign publish = enable && state == MEAS && rise;
  assign timeout = enable && state == MEAS && !rise && cnt == CMAX;
  // three-stage input path; rise detection uses the last two stages
  always_ff @(posedge clk)
    if (reset) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {pwm_in, s1, s2};
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // any rise restarts measurement; a full-length silent period while measuring means stuck
  always_comb begin
    state_nx = state;
    if (!enable) state_nx = IDLE;
    else if (rise) state_nx = MEAS;
    else if (timeout) state_nx = STUCK;
  end
  // period and high counters, restarted on every rise; bounded by the timeout so never wrap
  always_ff @(posedge clk)
    if (reset) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= PW'(1);
      hcnt <= PW'(1);
    end else if (state == MEAS && cnt != CMAX) begin
      cnt  <= cnt + PW'(1);
      hcnt <= hcnt + PW'(s2);
    end
  // result registers: publish on a rise during measurement, or report the stuck condition
  always_ff @(posedge clk)
    if (reset) begin
      duty_out     <= '0;
      high_count   <= '0;
      period_count <= '0;
      period_match <= 1'b0;
      valid        <= 1'b0;
      stuck        <= 1'b0;
      stuck_level  <= 1'b0;
    end else begin
      valid <= publish | timeout;
      if (publish) begin
        period_count <= cnt;
        high_count   <= hcnt;
        duty_out     <= hcnt > PW'(DSAT) ? DSAT : hcnt[R-1:0];
        period_match <= cnt == NOM;
        stuck        <= 1'b0;
      end else if (timeout) begin
        period_count <= '0;
        high_count   <= '0;
        duty_out     <= {R{s2}};
        period_match <= 1'b0;
        stuck        <= 1'b1;
        stuck_level  <= s2;
      end else if (enable && state == STUCK && rise) begin
        stuck <= 1'b0;
      end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed PWM stimulus checked against a rise-timestamp model
module tb_pwm_capture;
  localparam int R  = 8;
  localparam int PW = 12;
  localparam int TMAX = (1 << PW) - 1;
  localparam int M_IDLE = 0, M_MEAS = 1, M_STUCK = 2;
  logic clk = 0, reset = 1, enable = 1, pwm_in = 0;
  logic [R-1:0] duty_out;
  logic [PW-1:0] high_count, period_count;
  logic period_match, valid, stuck, stuck_level;
  int total = 0, bad = 0, cyc = 0, armed = 0;
  int mode = M_IDLE, last_rise = 0, ones = 0;
  logic h1 = 0, h2 = 0, h3 = 0;
  int e_period = 0, e_high = 0, e_duty = 0;
  logic e_match = 0, e_valid = 0, e_stuck = 0, e_level = 0;

  pwm_capture #(.R(R), .PW(PW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
    .duty_out(duty_out), .high_count(high_count), .period_count(period_count),
    .period_match(period_match), .valid(valid), .stuck(stuck), .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // reference: a rise is a 0->1 step in the sampled input; a period spans rise-to-rise
  always @(posedge clk) begin
    cyc++;
    e_valid = 0;
    if (reset) begin
      armed = 1; mode = M_IDLE; h1 = 0; h2 = 0; h3 = 0;
      e_period = 0; e_high = 0; e_duty = 0; e_match = 0; e_stuck = 0; e_level = 0;
    end else begin
      automatic logic rise = h2 & ~h3;
      automatic logic lvl = h2;
      h3 = h2; h2 = h1; h1 = pwm_in;
      if (!enable) mode = M_IDLE;
      else if (mode == M_MEAS && rise) begin
        e_period = cyc - last_rise; e_high = ones;
        e_duty = ones > 255 ? 255 : ones;
        e_match = (e_period == 256); e_stuck = 0; e_valid = 1;
        last_rise = cyc; ones = 1;
      end else if (rise) begin
        mode = M_MEAS; last_rise = cyc; ones = 1; e_stuck = 0;
      end else if (mode == M_MEAS && cyc - last_rise == TMAX) begin
        mode = M_STUCK; e_period = 0; e_high = 0; e_match = 0;
        e_stuck = 1; e_level = lvl; e_duty = lvl ? 255 : 0; e_valid = 1;
      end else if (mode == M_MEAS) ones += lvl;
    end
  end

  always @(negedge clk) if (armed) begin
    chk("valid", valid, e_valid);
    chk("stuck", stuck, e_stuck);
    chk("period_count", period_count, e_period);
    chk("high_count", high_count, e_high);
    chk("duty_out", duty_out, e_duty);
    chk("period_match", period_match, e_match);
    if (e_stuck) chk("stuck_level", stuck_level, e_level);
  end

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = v;
      @(negedge clk);
    end
  endtask

  task automatic pwm(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++)
      for (int i = 0; i < per; i++) begin
        pwm_in = (i < hi);
        @(negedge clk);
      end
  endtask

  initial begin
    @(negedge clk); @(negedge clk); @(negedge clk);
    reset = 0;
    pwm(256, 64, 4);
    pwm(256, 128, 4);
    hold(1, 5); hold(0, TMAX + 20);
    pwm(256, 64, 3);
    hold(0, 10); hold(1, TMAX + 20);
    pwm(256, 200, 3);
    pwm(256, 64, 1);
    pwm_in = 1; @(negedge clk);
    hold(1, 40); reset = 1; @(negedge clk); reset = 0;
    hold(1, 20); hold(0, 150);
    pwm(256, 64, 3);
    pwm(1000, 300, 3);
    enable = 0; hold(1, 5); hold(0, 5); enable = 1;
    pwm(1000, 300, 3);
    for (int k = 0; k < 30; k++) begin
      automatic int per = $urandom_range(700, 2);
      automatic int hi = $urandom_range(per - 1, 1);
      if ($urandom_range(5, 0) == 0) begin
        enable = 0;
        hold(pwm_in, $urandom_range(20, 1));
        enable = 1;
      end
      pwm(per, hi, $urandom_range(3, 1));
    end
    hold(0, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
